// File: rtl/mem_if_pkg.sv
// Types and defaults shared by the memory requester and the unified inst/data memory.
package mem_if_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } op_e;

endpackage

// File: rtl/mem_access_master.sv
// Requester side of the unified memory: runs one fetch/load/store per request,
// drives registered address/data/strobe and captures read data into IR or MDR.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a request; errors are answered here without access
// ST_READ  | address driven, settling; last edge captures into IR/MDR
// ST_WRITE | address/data/strobe driven; memory writes every edge
module mem_access_master
  import mem_if_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              load_req,
  input  logic              store_req,
  input  logic [31:0]       pc,
  input  logic [31:0]       alu_addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [3:0]          wait_q, wait_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mem_write_q, mem_write_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [31:0]         req_addr;
  logic [ADDR_W-1:0]   req_idx;
  logic                req_any;
  logic                req_bad;
  op_e                 req_op;
  logic                unused_addr_hi;

  // Store wins over load, load over fetch; losers are simply dropped.
  always_comb begin
    req_any = store_req | load_req | fetch_req;
    if (store_req) begin
      req_op   = OP_STORE;
      req_addr = alu_addr;
    end else if (load_req) begin
      req_op   = OP_LOAD;
      req_addr = alu_addr;
    end else begin
      req_op   = OP_FETCH;
      req_addr = pc;
    end
    req_idx = req_addr[ADDR_W+1:2];
    req_bad = (req_addr[1:0] != 2'b00) || ({1'b0, req_idx} >= DEPTH_L);
  end

  // Upper byte-address bits wrap and are intentionally ignored.
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    wait_d      = wait_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_write_d = mem_write_q;
    ir_d        = ir_q;
    mdr_d       = mdr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          if (req_bad) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            addr_d = req_idx;
            op_d   = req_op;
            wait_d = WAIT_L;
            busy_d = 1'b1;
            if (req_op == OP_STORE) begin
              wdata_d     = store_data;
              mem_write_d = 1'b1;
              state_d     = ST_WRITE;
            end else begin
              state_d = ST_READ;
            end
          end
        end
      end
      ST_READ: begin
        if (wait_q == 4'd0) begin
          if (op_q == OP_FETCH) ir_d = mem_read_data;
          else                  mdr_d = mem_read_data;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_WRITE: begin
        if (wait_q == 4'd0) begin
          mem_write_d = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        busy_d      = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_FETCH;
      wait_q      <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_write_q <= 1'b0;
      ir_q        <= '0;
      mdr_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      wait_q      <= wait_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_write_q <= mem_write_d;
      ir_q        <= ir_d;
      mdr_q       <= mdr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_write      = mem_write_q;
  assign ir             = ir_q;
  assign mdr            = mdr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Bench for mem_access_master: instance 0 with no wait cycles, instance 1 with two.
module tb_mem_access_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req [2];
  logic        load_req  [2];
  logic        store_req [2];
  logic [31:0] pc        [2];
  logic [31:0] alu_addr  [2];
  logic [31:0] store_data[2];
  logic [31:0] mem_read_data [2];
  logic [5:0]  mem_address   [2];
  logic [31:0] mem_write_data[2];
  logic        mem_write [2];
  logic [31:0] ir        [2];
  logic [31:0] mdr       [2];
  logic        busy      [2];
  logic        done      [2];
  logic        err       [2];

  logic [31:0] mem [2][32];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_master #(.DATA_W(32), .ADDR_W(6), .DEPTH(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req[0]), .load_req(load_req[0]), .store_req(store_req[0]),
    .pc(pc[0]), .alu_addr(alu_addr[0]), .store_data(store_data[0]),
    .mem_read_data(mem_read_data[0]), .mem_address(mem_address[0]),
    .mem_write_data(mem_write_data[0]), .mem_write(mem_write[0]),
    .ir(ir[0]), .mdr(mdr[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  mem_access_master #(.DATA_W(32), .ADDR_W(6), .DEPTH(32), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req[1]), .load_req(load_req[1]), .store_req(store_req[1]),
    .pc(pc[1]), .alu_addr(alu_addr[1]), .store_data(store_data[1]),
    .mem_read_data(mem_read_data[1]), .mem_address(mem_address[1]),
    .mem_write_data(mem_write_data[1]), .mem_write(mem_write[1]),
    .ir(ir[1]), .mdr(mdr[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  always @(posedge clk) begin
    if (mem_write[0]) mem[0][mem_address[0][4:0]] <= mem_write_data[0];
    if (mem_write[1]) mem[1][mem_address[1][4:0]] <= mem_write_data[1];
  end
  assign mem_read_data[0] = mem[0][mem_address[0][4:0]];
  assign mem_read_data[1] = mem[1][mem_address[1][4:0]];

  typedef struct {
    logic        f, l, s;
    logic [31:0] pc_v, alu_v, sd_v;
    int          lat;
    int          mw;
    logic        err_v;
    logic [5:0]  addr_v;
    logic [31:0] ir_v, mdr_v;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request for a single cycle, then follow it until done (bounded).
  task automatic run_op(input int w, input logic f, input logic l, input logic s,
                        input logic [31:0] pc_v, input logic [31:0] alu_v,
                        input logic [31:0] sd_v, output int lat, output int mw_cnt,
                        output logic err_v, output logic [5:0] addr_v);
    fetch_req[w] = f; load_req[w] = l; store_req[w] = s;
    pc[w] = pc_v; alu_addr[w] = alu_v; store_data[w] = sd_v;
    step();
    fetch_req[w] = 1'b0; load_req[w] = 1'b0; store_req[w] = 1'b0;
    lat = 1;
    mw_cnt = 0;
    addr_v = mem_address[w];
    while (!done[w] && lat < 30) begin
      if (mem_write[w]) mw_cnt++;
      step();
      lat++;
    end
    if (mem_write[w]) mw_cnt++;
    err_v = err[w];
    if (!done[w]) lat = -1;
  endtask

  initial begin
    int lat, mw, nd;
    logic e;
    logic [5:0] a;

    for (int w = 0; w < 2; w++) begin
      fetch_req[w] = 0; load_req[w] = 0; store_req[w] = 0;
      pc[w] = 0; alu_addr[w] = 0; store_data[w] = 0;
    end

    //          f  l  s  pc            alu           store_data    lat mw err addr ir            mdr
    vt[0]  = '{0, 0, 1, 32'h0,        32'h04,       32'h8c640000, 2, 1, 0, 1,  32'h0,        32'h0};
    vt[1]  = '{1, 0, 0, 32'h04,       32'h0,        32'h0,        2, 0, 0, 1,  32'h8c640000, 32'h0};
    vt[2]  = '{0, 0, 1, 32'h0,        32'h0C,       32'hDEADBEEF, 2, 1, 0, 3,  32'h8c640000, 32'h0};
    vt[3]  = '{0, 1, 0, 32'h0,        32'h0C,       32'h0,        2, 0, 0, 3,  32'h8c640000, 32'hDEADBEEF};
    vt[4]  = '{1, 1, 1, 32'h04,       32'h08,       32'h12345678, 2, 1, 0, 2,  32'h8c640000, 32'hDEADBEEF};
    vt[5]  = '{0, 1, 0, 32'h0,        32'h08,       32'h0,        2, 0, 0, 2,  32'h8c640000, 32'h12345678};
    vt[6]  = '{0, 1, 0, 32'h0,        32'h06,       32'h0,        1, 0, 1, 2,  32'h8c640000, 32'h12345678};
    vt[7]  = '{0, 1, 0, 32'h0,        32'h80,       32'h0,        1, 0, 1, 2,  32'h8c640000, 32'h12345678};
    vt[8]  = '{0, 0, 1, 32'h0,        32'h7C,       32'hA5A55A5A, 2, 1, 0, 31, 32'h8c640000, 32'h12345678};
    vt[9]  = '{1, 0, 0, 32'h7C,       32'h0,        32'h0,        2, 0, 0, 31, 32'hA5A55A5A, 32'h12345678};
    vt[10] = '{0, 1, 0, 32'h0,        32'h10000004, 32'h0,        2, 0, 0, 1,  32'hA5A55A5A, 32'h8c640000};
    vt[11] = '{1, 0, 0, 32'h02,       32'h0,        32'h0,        1, 0, 1, 1,  32'hA5A55A5A, 32'h8c640000};
    vt[12] = '{1, 1, 0, 32'h04,       32'hFC,       32'h0,        1, 0, 1, 1,  32'hA5A55A5A, 32'h8c640000};
    vt[13] = '{1, 1, 0, 32'h7C,       32'h0C,       32'h0,        2, 0, 0, 3,  32'hA5A55A5A, 32'hDEADBEEF};
    vt[14] = '{0, 0, 1, 32'h0,        32'h0E,       32'hFFFFFFFF, 1, 0, 1, 3,  32'hA5A55A5A, 32'hDEADBEEF};
    vt[15] = '{0, 1, 0, 32'h0,        32'h0C,       32'h0,        2, 0, 0, 3,  32'hA5A55A5A, 32'hDEADBEEF};

    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("rst_addr%0d", w), 32'(mem_address[w]), 32'h0);
      chk($sformatf("rst_wdata%0d", w), mem_write_data[w], 32'h0);
      chk($sformatf("rst_ir%0d", w), ir[w], 32'h0);
      chk($sformatf("rst_mdr%0d", w), mdr[w], 32'h0);
      chk($sformatf("rst_flags%0d", w),
          {28'h0, mem_write[w], busy[w], done[w], err[w]}, 32'h0);
    end

    for (int i = 0; i < 16; i++) begin
      run_op(0, vt[i].f, vt[i].l, vt[i].s, vt[i].pc_v, vt[i].alu_v, vt[i].sd_v,
             lat, mw, e, a);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d_mem_write_cycles", i), 32'(mw), 32'(vt[i].mw));
      chk($sformatf("v%0d_err", i), 32'(e), 32'(vt[i].err_v));
      chk($sformatf("v%0d_mem_address", i), 32'(a), 32'(vt[i].addr_v));
      chk($sformatf("v%0d_ir", i), ir[0], vt[i].ir_v);
      chk($sformatf("v%0d_mdr", i), mdr[0], vt[i].mdr_v);
    end
    chk("mem3_after_stores", mem[0][3], 32'hDEADBEEF);

    // Two wait cycles: store holds the strobe three cycles, done four cycles after accept.
    run_op(1, 0, 0, 1, 32'h0, 32'h10, 32'hCAFEF00D, lat, mw, e, a);
    chk("w2_store_latency", 32'(lat), 32'd4);
    chk("w2_store_mw_cycles", 32'(mw), 32'd3);
    chk("w2_store_mem", mem[1][4], 32'hCAFEF00D);
    run_op(1, 0, 1, 0, 32'h0, 32'h10, 32'h0, lat, mw, e, a);
    chk("w2_load_latency", 32'(lat), 32'd4);
    chk("w2_load_mdr", mdr[1], 32'hCAFEF00D);

    // A store raised while a load is in flight must be ignored entirely.
    load_req[1] = 1'b1; alu_addr[1] = 32'h10;
    step();
    load_req[1] = 1'b0;
    store_req[1] = 1'b1; alu_addr[1] = 32'h14; store_data[1] = 32'hFFFFFFFF;
    mw = 0;
    lat = 1;
    if (mem_write[1]) mw++;
    step();
    store_req[1] = 1'b0;
    lat++;
    while (!done[1] && lat < 30) begin
      if (mem_write[1]) mw++;
      step();
      lat++;
    end
    chk("ignore_latency", 32'(lat), 32'd4);
    step();
    if (mem_write[1]) mw++;
    chk("ignore_mw_cycles", 32'(mw), 32'd0);
    chk("ignore_busy", 32'(busy[1]), 32'd0);
    chk("ignore_mem5", mem[1][5], 32'h0);

    // Reset while the write strobe is high: that edge still writes.
    store_req[1] = 1'b1; alu_addr[1] = 32'h14; store_data[1] = 32'h0BADCAFE;
    step();
    store_req[1] = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_write_mem5", mem[1][5], 32'h0BADCAFE);
    chk("rst_write_flags", {29'h0, mem_write[1], busy[1], done[1]}, 32'h0);
    chk("rst_write_mdr", mdr[1], 32'h0);
    chk("rst_dut0_ir", ir[0], 32'h0);

    // Reset in READ: no done pulse, IR stays cleared.
    fetch_req[1] = 1'b1; pc[1] = 32'h10;
    step();
    fetch_req[1] = 1'b0;
    chk("rd_busy_before_rst", 32'(busy[1]), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      if (done[1]) nd++;
      step();
    end
    chk("rst_read_done_pulses", 32'(nd), 32'd0);
    chk("rst_read_busy", 32'(busy[1]), 32'd0);
    chk("rst_read_ir", ir[1], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
